// File: rtl/bcd_pkg.sv
// Shared types and helpers for the shared binary-to-BCD converter and its arbiter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADD3        = 4'd3;

  function automatic logic [3:0] add3_correct(input logic [3:0] nibble);
    return (nibble >= BCD_ADD3_THRESH) ? nibble + BCD_ADD3 : nibble;
  endfunction

endpackage

// File: rtl/bcd_shift_engine.sv
// Iterative shift/add-3 engine: one nibble correction plus one left shift per enabled cycle.
module bcd_shift_engine
  import bcd_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [IN_W-1:0]       data,
  input  logic                  step,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  done_cnt
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  logic [DIGITS*4-1:0] bcd_r;
  logic [DIGITS*4-1:0] corrected;
  logic [DIGITS*4-1:0] shifted;
  logic [IN_W-1:0]     bin_r;
  logic [CNT_W-1:0]    cnt_r;

  // bcd presents the value after the current step so the caller can capture it on the final shift edge
  always_comb begin
    corrected = '0;
    for (int d = 0; d < DIGITS; d++) begin
      corrected[d*4 +: 4] = add3_correct(bcd_r[d*4 +: 4]);
    end
    shifted = (corrected << 1) | {{(DIGITS*4-1){1'b0}}, bin_r[IN_W-1]};
  end

  assign bcd      = shifted;
  assign done_cnt = (cnt_r == CNT_W'(IN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_r <= '0;
      bin_r <= '0;
      cnt_r <= '0;
    end else if (load) begin
      bcd_r <= '0;
      bin_r <= data;
      cnt_r <= '0;
    end else if (step) begin
      bcd_r <= shifted;
      bin_r <= bin_r << 1;
      cnt_r <= cnt_r + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shift/add-3 BCD engine and returns the result with its owner id.
// Define BCD_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  IN_W    = 12,
  parameter int  DIGITS  = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGITS*4-1:0]     out_bcd,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy
);

  if ((10 ** DIGITS) <= (2 ** IN_W - 1)) begin : g_digits_check
    $error("bcd_convert_arbiter: DIGITS too small for IN_W");
  end

  state_t              state_r, state_nx;
  logic                grant_any;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cur_id_r;
  logic [ID_W-1:0]     out_id_r;
  logic [DIGITS*4-1:0] out_bcd_r;
  logic [DIGITS*4-1:0] eng_bcd;
  logic                load;
  logic                step;
  logic                done_cnt;

`ifdef BCD_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Search begins at the pointer and wraps, so the most recent winner is considered last
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end
`endif

  bcd_shift_engine #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data     (req_data[grant_idx*IN_W +: IN_W]),
    .step     (step),
    .bcd      (eng_bcd),
    .done_cnt (done_cnt)
  );

  // Grants are held off while reset is asserted so every output reads zero during reset
  always_comb begin
    state_nx  = state_r;
    req_ready = '0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_any && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          load                 = 1'b1;
          state_nx             = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (done_cnt) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cur_id_r  <= '0;
      out_id_r  <= '0;
      out_bcd_r <= '0;
    end else begin
      state_r <= state_nx;
      if (load) cur_id_r <= grant_idx;
      if (state_r == SHIFT && done_cnt) begin
        out_bcd_r <= eng_bcd;
        out_id_r  <= cur_id_r;
      end
    end
  end

  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_bcd   = out_bcd_r;
  assign out_id    = out_id_r;

endmodule
